reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
// - ARM-style 16 x 32-bit register file for the decode/issue stage of the pipelined core.
// - Provides four source reads plus a PC read port.
// - Accepts ALU/load write-back, base-register update (pre/post-index) and PC update writes.
// - A per-register pending scoreboard raises stall when an issuing read targets a register
//   whose write-back is still outstanding. r15 is the PC.
// PARAMETERS
// - NREG   16  number of registers (r0..r15, r15 = PC)
// - DW     32  data width
// PORTS
// - clk                 in   1   rising-edge clock
// - rst                 in   1   asynchronous, active-high reset
// - read_1..read_4      in   1   read enables: out_src1 <- src1_add, out_src2 <- src2_add,
//                                out_src3 <- src3_add (shift-by-register), out_src4 <- dest_add (store data)
// - read_pc             in   1   latch PC into pc_content
// - write               in   1   write data_write to write_back_address, clear its pending bit
// - write_pc            in   1   load pc_next into r15
// - reg_update          in   1   write reg_update_data to reg_update_address, clear its pending bit
// - set_write_bit       in   1   mark dest_add pending
// - set_reg_update      in   1   mark src1_add (base register) pending
// - src1_add/src2_add/src3_add/dest_add   in  4   read / destination addresses
// - write_back_address  in   4   write-back target
// - reg_update_address  in   4   base-update target
// - data_write/pc_next/reg_update_data    in  32  write data
// - pc_content          out  32  registered PC value
// - out_src1..out_src4  out  32  registered read data
// - stall               out  1   combinational hazard flag
// BEHAVIOUR
// - Reset (async): all registers, all pending bits and all outputs = 0.
// - Reads: on posedge with read_N=1 and stall=0, out_srcN <= reg[addr]; otherwise holds.
//   Latency is 1 cycle. pc_content <= r15 when read_pc=1, regardless of stall.
// - Same-cycle bypass: if write/reg_update/write_pc target a read address, the new data is latched.
//   Address 15 reads return the PC.
// - Writes on posedge:
//   - write: reg[write_back_address] <= data_write
//   - reg_update: reg[reg_update_address] <= reg_update_data
//   - write_pc: r15 <= pc_next
//   - Priority on same address: write_pc > write > reg_update.
// - Pending bits:
//   - write clears pending[write_back_address]; reg_update clears pending[reg_update_address].
//   - set_write_bit sets pending[dest_add]; set_reg_update sets pending[src1_add].
//   - Sets are ignored while stall=1 (instruction not issued).
//   - Set and clear on the same address in the same cycle: set wins.
// - stall = OR over enabled reads (read_1..read_4) of pending[addr], excluding any address
//   being cleared by write/reg_update in the same cycle. stall never blocks writes.
// - No X propagation: unused enables leave state unchanged.
// TESTING
// - Reset -> all out_src*, pc_content, stall = 0; read r4 -> 0.
// - set_write_bit, dest_add=12 -> next cycle read_2, src2_add=12 -> stall=1, out_src2 holds.
// - write=1, write_back_address=12, data_write=5, read_2 on r12 same cycle -> stall=0,
//   out_src2=5, pending[12] cleared.
// - set_reg_update, src1_add=4 -> read r4 stalls; reg_update, address 4, data 11
//   -> r4=11, stall drops.
// - write_pc, pc_next=4, then read_pc -> pc_content=4; read src1_add=15 -> 4.
// - Assert rst mid-stall -> pending cleared, stall=0, outputs 0 immediately.

Source files
------------

// File: rtl/reg_file_if.sv
// Issue-stage register file bus: read/write enables, addresses, write data and read results.
interface reg_file_if #(
    parameter int NREG = 16,
    parameter int DW   = 32
);
    localparam int AW = $clog2(NREG);

    logic          read_1, read_2, read_3, read_4, read_pc;
    logic          write, write_pc, reg_update;
    logic          set_write_bit, set_reg_update;
    logic [AW-1:0] src1_add, src2_add, src3_add, dest_add;
    logic [AW-1:0] write_back_address, reg_update_address;
    logic [DW-1:0] data_write, pc_next, reg_update_data;
    logic [DW-1:0] pc_content;
    logic [DW-1:0] out_src1, out_src2, out_src3, out_src4;
    logic          stall;

    modport master (
        output read_1, read_2, read_3, read_4, read_pc,
        output write, write_pc, reg_update, set_write_bit, set_reg_update,
        output src1_add, src2_add, src3_add, dest_add,
        output write_back_address, reg_update_address,
        output data_write, pc_next, reg_update_data,
        input  pc_content, out_src1, out_src2, out_src3, out_src4, stall
    );

    modport slave (
        input  read_1, read_2, read_3, read_4, read_pc,
        input  write, write_pc, reg_update, set_write_bit, set_reg_update,
        input  src1_add, src2_add, src3_add, dest_add,
        input  write_back_address, reg_update_address,
        input  data_write, pc_next, reg_update_data,
        output pc_content, out_src1, out_src2, out_src3, out_src4, stall
    );
endinterface

// File: rtl/reg_file.sv
// 16 x 32 register file (r15 = PC) with write-back/base-update/PC writes, same-cycle
// bypass on all read ports and a per-register pending scoreboard that drives stall.
module reg_file #(
    parameter int NREG = 16,
    parameter int DW   = 32
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);
    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] clr_mask, pend_eff;
    logic [DW-1:0]   out_src1_q, out_src2_q, out_src3_q, out_src4_q, pc_content_q;
    logic [DW-1:0]   out_src1_d, out_src2_d, out_src3_d, out_src4_d, pc_content_d;
    logic            stall;

    // A register whose write-back lands this cycle is no longer a hazard.
    always_comb begin
        clr_mask = '0;
        if (bus.write)      clr_mask[bus.write_back_address] = 1'b1;
        if (bus.reg_update) clr_mask[bus.reg_update_address] = 1'b1;
        pend_eff = pend_q & ~clr_mask;
        stall = (bus.read_1 && pend_eff[bus.src1_add]) ||
                (bus.read_2 && pend_eff[bus.src2_add]) ||
                (bus.read_3 && pend_eff[bus.src3_add]) ||
                (bus.read_4 && pend_eff[bus.dest_add]);
    end

    // Applied lowest priority first so write_pc > write > reg_update on a shared address.
    always_comb begin
        for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
        if (bus.reg_update) regs_d[bus.reg_update_address] = bus.reg_update_data;
        if (bus.write)      regs_d[bus.write_back_address] = bus.data_write;
        if (bus.write_pc)   regs_d[NREG-1]                 = bus.pc_next;
    end

    always_comb begin
        pend_d = pend_eff;
        if (!stall) begin
            if (bus.set_write_bit)  pend_d[bus.dest_add] = 1'b1;
            if (bus.set_reg_update) pend_d[bus.src1_add] = 1'b1;
        end
    end

    // Reads sample the post-write values, giving the same-cycle bypass.
    always_comb begin
        out_src1_d   = out_src1_q;
        out_src2_d   = out_src2_q;
        out_src3_d   = out_src3_q;
        out_src4_d   = out_src4_q;
        pc_content_d = pc_content_q;
        if (!stall) begin
            if (bus.read_1) out_src1_d = regs_d[bus.src1_add];
            if (bus.read_2) out_src2_d = regs_d[bus.src2_add];
            if (bus.read_3) out_src3_d = regs_d[bus.src3_add];
            if (bus.read_4) out_src4_d = regs_d[bus.dest_add];
        end
        if (bus.read_pc) pc_content_d = regs_d[NREG-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            pend_q       <= '0;
            out_src1_q   <= '0;
            out_src2_q   <= '0;
            out_src3_q   <= '0;
            out_src4_q   <= '0;
            pc_content_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            pend_q       <= pend_d;
            out_src1_q   <= out_src1_d;
            out_src2_q   <= out_src2_d;
            out_src3_q   <= out_src3_d;
            out_src4_q   <= out_src4_d;
            pc_content_q <= pc_content_d;
        end
    end

    assign bus.stall      = stall;
    assign bus.out_src1   = out_src1_q;
    assign bus.out_src2   = out_src2_q;
    assign bus.out_src3   = out_src3_q;
    assign bus.out_src4   = out_src4_q;
    assign bus.pc_content = pc_content_q;
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed hazard/bypass/PC/priority scenarios plus randomized
// traffic against an array-based reference model.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_if #(.NREG(16), .DW(32)) bus ();
    reg_file #(.NREG(16), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [16];
    bit          m_pend [16];
    logic [31:0] m_out  [4];
    logic [31:0] m_pc;
    bit          m_stall;
    bit          seen_stall;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_pc    = '0;
        m_stall = 1'b0;
    endtask

    function automatic bit model_stall();
        bit         s = 1'b0;
        bit         en [4];
        logic [3:0] a  [4];
        en[0] = bus.read_1; a[0] = bus.src1_add;
        en[1] = bus.read_2; a[1] = bus.src2_add;
        en[2] = bus.read_3; a[2] = bus.src3_add;
        en[3] = bus.read_4; a[3] = bus.dest_add;
        for (int n = 0; n < 4; n++)
            if (en[n] && m_pend[a[n]] &&
                !(bus.write && bus.write_back_address == a[n]) &&
                !(bus.reg_update && bus.reg_update_address == a[n]))
                s = 1'b1;
        return s;
    endfunction

    task automatic model_step();
        logic [31:0] nr [16];
        bit s;
        s = model_stall();
        m_stall = s;
        nr = m_regs;
        if (bus.reg_update) nr[bus.reg_update_address] = bus.reg_update_data;
        if (bus.write)      nr[bus.write_back_address] = bus.data_write;
        if (bus.write_pc)   nr[15] = bus.pc_next;
        if (!s) begin
            if (bus.read_1) m_out[0] = nr[bus.src1_add];
            if (bus.read_2) m_out[1] = nr[bus.src2_add];
            if (bus.read_3) m_out[2] = nr[bus.src3_add];
            if (bus.read_4) m_out[3] = nr[bus.dest_add];
        end
        if (bus.read_pc) m_pc = nr[15];
        if (bus.write)      m_pend[bus.write_back_address] = 1'b0;
        if (bus.reg_update) m_pend[bus.reg_update_address] = 1'b0;
        if (!s) begin
            if (bus.set_write_bit)  m_pend[bus.dest_add] = 1'b1;
            if (bus.set_reg_update) m_pend[bus.src1_add] = 1'b1;
        end
        m_regs = nr;
    endtask

    task automatic clear_inputs();
        bus.read_1 = 0; bus.read_2 = 0; bus.read_3 = 0; bus.read_4 = 0; bus.read_pc = 0;
        bus.write = 0; bus.write_pc = 0; bus.reg_update = 0;
        bus.set_write_bit = 0; bus.set_reg_update = 0;
        bus.src1_add = 0; bus.src2_add = 0; bus.src3_add = 0; bus.dest_add = 0;
        bus.write_back_address = 0; bus.reg_update_address = 0;
        bus.data_write = 0; bus.pc_next = 0; bus.reg_update_data = 0;
    endtask

    // Inputs are set by the caller just after a rising edge; stall is sampled at the falling edge.
    task automatic drive_cycle();
        @(negedge clk);
        #1;
        seen_stall = bus.stall;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] got [5];
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #12;
        got[0] = bus.out_src1; got[1] = bus.out_src2; got[2] = bus.out_src3;
        got[3] = bus.out_src4; got[4] = bus.pc_content;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== 32'd0) begin
                failures++;
                $display("FAIL reset_out[%0d] got=%0h exp=0", i, got[i]);
            end
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b exp=0", bus.stall);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_inputs();
        bus.read_1 = 1; bus.src1_add = 4;
        drive_cycle();
        checks++;
        if (bus.out_src1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_read_r4 got=%0h exp=0", bus.out_src1);
        end
    endtask

    task automatic test_write_hazard();
        clear_inputs();
        bus.read_2 = 1; bus.src2_add = 1; bus.write = 1; bus.write_back_address = 1;
        bus.data_write = 32'h77;
        drive_cycle();
        clear_inputs();
        bus.set_write_bit = 1; bus.dest_add = 12;
        drive_cycle();
        clear_inputs();
        bus.read_2 = 1; bus.src2_add = 12;
        drive_cycle();
        checks++;
        if (seen_stall !== 1'b1) begin
            failures++;
            $display("FAIL hazard_stall got=%b exp=1", seen_stall);
        end
        checks++;
        if (bus.out_src2 !== 32'h77) begin
            failures++;
            $display("FAIL hazard_hold got=%0h exp=77", bus.out_src2);
        end
        clear_inputs();
        bus.read_2 = 1; bus.src2_add = 12;
        bus.write = 1; bus.write_back_address = 12; bus.data_write = 32'd5;
        drive_cycle();
        checks++;
        if (seen_stall !== 1'b0) begin
            failures++;
            $display("FAIL wb_clear_stall got=%b exp=0", seen_stall);
        end
        checks++;
        if (bus.out_src2 !== 32'd5) begin
            failures++;
            $display("FAIL wb_bypass got=%0h exp=5", bus.out_src2);
        end
        clear_inputs();
        bus.read_2 = 1; bus.src2_add = 12;
        drive_cycle();
        checks++;
        if (seen_stall !== 1'b0) begin
            failures++;
            $display("FAIL wb_pending_cleared got=%b exp=0", seen_stall);
        end
    endtask

    task automatic test_reg_update();
        clear_inputs();
        bus.set_reg_update = 1; bus.src1_add = 4;
        drive_cycle();
        clear_inputs();
        bus.read_1 = 1; bus.src1_add = 4;
        drive_cycle();
        checks++;
        if (seen_stall !== 1'b1) begin
            failures++;
            $display("FAIL base_stall got=%b exp=1", seen_stall);
        end
        clear_inputs();
        bus.read_1 = 1; bus.src1_add = 4;
        bus.reg_update = 1; bus.reg_update_address = 4; bus.reg_update_data = 32'd11;
        drive_cycle();
        checks++;
        if (seen_stall !== 1'b0) begin
            failures++;
            $display("FAIL base_update_stall got=%b exp=0", seen_stall);
        end
        checks++;
        if (bus.out_src1 !== 32'd11) begin
            failures++;
            $display("FAIL base_update_data got=%0h exp=b", bus.out_src1);
        end
    endtask

    task automatic test_pc();
        clear_inputs();
        bus.write_pc = 1; bus.pc_next = 32'd4;
        drive_cycle();
        clear_inputs();
        bus.read_pc = 1;
        drive_cycle();
        checks++;
        if (bus.pc_content !== 32'd4) begin
            failures++;
            $display("FAIL pc_read got=%0h exp=4", bus.pc_content);
        end
        clear_inputs();
        bus.read_1 = 1; bus.src1_add = 15;
        drive_cycle();
        checks++;
        if (bus.out_src1 !== 32'd4) begin
            failures++;
            $display("FAIL pc_via_src1 got=%0h exp=4", bus.out_src1);
        end
    endtask

    task automatic test_priority();
        clear_inputs();
        bus.read_3 = 1; bus.src3_add = 15;
        bus.write_pc = 1; bus.pc_next = 32'h100;
        bus.write = 1; bus.write_back_address = 15; bus.data_write = 32'h200;
        bus.reg_update = 1; bus.reg_update_address = 15; bus.reg_update_data = 32'h300;
        drive_cycle();
        checks++;
        if (bus.out_src3 !== 32'h100) begin
            failures++;
            $display("FAIL prio_pc got=%0h exp=100", bus.out_src3);
        end
        clear_inputs();
        bus.read_4 = 1; bus.dest_add = 7;
        bus.write = 1; bus.write_back_address = 7; bus.data_write = 32'hAA;
        bus.reg_update = 1; bus.reg_update_address = 7; bus.reg_update_data = 32'hBB;
        drive_cycle();
        checks++;
        if (bus.out_src4 !== 32'hAA) begin
            failures++;
            $display("FAIL prio_write got=%0h exp=aa", bus.out_src4);
        end
        // set and clear of r9 together: the set must survive
        clear_inputs();
        bus.set_write_bit = 1; bus.dest_add = 9;
        bus.write = 1; bus.write_back_address = 9; bus.data_write = 32'h9;
        drive_cycle();
        clear_inputs();
        bus.read_3 = 1; bus.src3_add = 9;
        drive_cycle();
        checks++;
        if (seen_stall !== 1'b1) begin
            failures++;
            $display("FAIL set_wins got=%b exp=1", seen_stall);
        end
        // a stalled cycle must not mark r3 pending
        clear_inputs();
        bus.read_3 = 1; bus.src3_add = 9; bus.set_write_bit = 1; bus.dest_add = 3;
        drive_cycle();
        clear_inputs();
        bus.write = 1; bus.write_back_address = 9;
        drive_cycle();
        clear_inputs();
        bus.read_1 = 1; bus.src1_add = 3;
        drive_cycle();
        checks++;
        if (seen_stall !== 1'b0) begin
            failures++;
            $display("FAIL set_ignored_on_stall got=%b exp=0", seen_stall);
        end
    endtask

    task automatic test_random();
        logic [31:0] got [5];
        logic [31:0] exp [5];
        for (int c = 0; c < 400; c++) begin
            bus.read_1 = 1'($urandom_range(0, 1));
            bus.read_2 = 1'($urandom_range(0, 1));
            bus.read_3 = 1'($urandom_range(0, 1));
            bus.read_4 = 1'($urandom_range(0, 1));
            bus.read_pc = 1'($urandom_range(0, 1));
            bus.write = ($urandom_range(0, 3) != 0);
            bus.reg_update = ($urandom_range(0, 2) == 0);
            bus.write_pc = ($urandom_range(0, 5) == 0);
            bus.set_write_bit = ($urandom_range(0, 3) == 0);
            bus.set_reg_update = ($urandom_range(0, 5) == 0);
            bus.src1_add = 4'($urandom); bus.src2_add = 4'($urandom);
            bus.src3_add = 4'($urandom); bus.dest_add = 4'($urandom);
            bus.write_back_address = 4'($urandom);
            bus.reg_update_address = 4'($urandom);
            bus.data_write = $urandom; bus.pc_next = $urandom; bus.reg_update_data = $urandom;
            drive_cycle();
            checks++;
            if (seen_stall !== m_stall) begin
                failures++;
                $display("FAIL rand_stall cyc=%0d got=%b exp=%b", c, seen_stall, m_stall);
            end
            got[0] = bus.out_src1; got[1] = bus.out_src2; got[2] = bus.out_src3;
            got[3] = bus.out_src4; got[4] = bus.pc_content;
            exp[0] = m_out[0]; exp[1] = m_out[1]; exp[2] = m_out[2];
            exp[3] = m_out[3]; exp[4] = m_pc;
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL rand_out[%0d] cyc=%0d got=%0h exp=%0h", i, c, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] got [5];
        clear_inputs();
        bus.read_1 = 1; bus.src1_add = 6; bus.read_pc = 1;
        bus.write = 1; bus.write_back_address = 6; bus.data_write = 32'h66;
        bus.write_pc = 1; bus.pc_next = 32'h44;
        drive_cycle();
        clear_inputs();
        bus.set_write_bit = 1; bus.dest_add = 6;
        drive_cycle();
        clear_inputs();
        bus.read_1 = 1; bus.src1_add = 6;
        drive_cycle();
        #2;
        checks++;
        if (bus.stall !== 1'b1 || bus.out_src1 !== 32'h66) begin
            failures++;
            $display("FAIL pre_reset_state stall=%b out1=%0h exp stall=1 out1=66",
                     bus.stall, bus.out_src1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_stall got=%b exp=0", bus.stall);
        end
        got[0] = bus.out_src1; got[1] = bus.out_src2; got[2] = bus.out_src3;
        got[3] = bus.out_src4; got[4] = bus.pc_content;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== 32'd0) begin
                failures++;
                $display("FAIL mid_reset_out[%0d] got=%0h exp=0", i, got[i]);
            end
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_inputs();
        bus.read_1 = 1; bus.src1_add = 6; bus.read_pc = 1;
        drive_cycle();
        checks++;
        if (seen_stall !== 1'b0 || bus.out_src1 !== 32'd0 || bus.pc_content !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_read stall=%b out1=%0h pc=%0h exp all 0",
                     seen_stall, bus.out_src1, bus.pc_content);
        end
    endtask

    initial begin
        test_reset();
        test_write_hazard();
        test_reg_update();
        test_pc();
        test_priority();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
